// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - two-port single-RAM arbiter; ARB_ROUND_ROBIN_EN selects round-robin over fixed m0 priority
module ram_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              m0_req_i,
    input  logic              m0_we_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [DATA_W-1:0] m0_wdata_i,
    output logic              m0_gnt_o,
    output logic              m0_rvalid_o,
    output logic [DATA_W-1:0] m0_rdata_o,
    input  logic              m1_req_i,
    input  logic              m1_we_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [DATA_W-1:0] m1_wdata_i,
    output logic              m1_gnt_o,
    output logic              m1_rvalid_o,
    output logic [DATA_W-1:0] m1_rdata_o,
    output logic              ram_wen_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_din_o,
    input  logic [DATA_W-1:0] ram_dout_i,
    output logic              busy_o
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t              state_q, state_d;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                id_q;
    logic                any_req;
    logic                win_id;
    logic                take;
    logic                in_access;
    logic                in_resp;

    assign any_req = m0_req_i | m1_req_i;
    // Arbitration window is every cycle outside ACCESS; requests seen in ACCESS wait for RESP.
    assign take    = (state_q != ACCESS) && any_req;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_m1_q;

    // On a tie the port that was not granted last wins.
    assign win_id = (m0_req_i && m1_req_i) ? ~last_m1_q : ~m0_req_i;

    // Round-robin pointer remembers the most recent winner.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            last_m1_q <= 1'b1;
        end else if (take) begin
            last_m1_q <= win_id;
        end
    end
`else
    // Fixed priority: m0 wins whenever it requests.
    assign win_id = ~m0_req_i;
`endif

    // Next-state logic: one ACCESS cycle, then RESP, which can re-arbitrate immediately.
    always_comb begin
        state_d = IDLE;
        case (state_q)
            IDLE:    state_d = any_req ? ACCESS : IDLE;
            ACCESS:  state_d = RESP;
            RESP:    state_d = any_req ? ACCESS : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, winner's request latch and read-data capture.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            id_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (take) begin
                id_q    <= win_id;
                we_q    <= win_id ? m1_we_i    : m0_we_i;
                addr_q  <= win_id ? m1_addr_i  : m0_addr_i;
                wdata_q <= win_id ? m1_wdata_i : m0_wdata_i;
            end
            if (state_q == ACCESS && !we_q) begin
                rdata_q <= ram_dout_i;
            end
        end
    end

    // Everything is forced quiet while reset is held so a reset in ACCESS cannot write or respond.
    assign in_access   = rst_ni && (state_q == ACCESS);
    assign in_resp     = rst_ni && (state_q == RESP);

    assign m0_gnt_o    = in_access && !id_q;
    assign m1_gnt_o    = in_access &&  id_q;
    assign m0_rvalid_o = in_resp && !we_q && !id_q;
    assign m1_rvalid_o = in_resp && !we_q &&  id_q;
    assign m0_rdata_o  = rst_ni ? rdata_q : '0;
    assign m1_rdata_o  = rst_ni ? rdata_q : '0;
    assign ram_wen_o   = in_access && we_q;
    assign ram_addr_o  = rst_ni ? addr_q  : '0;
    assign ram_din_o   = rst_ni ? wdata_q : '0;
    assign busy_o      = rst_ni && (state_q != IDLE);

endmodule
